food_placer: RTL and testbench



---
 rtl/food_placer_pkg.sv | 28 ++
 rtl/food_placer_scan.sv | 41 ++++
 rtl/food_placer.sv | 192 +++++++++++++++++++
 tb/tb_food_placer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/food_placer_pkg.sv
// Shared types and constants for the food placement controller.
// The SCAN state exists only when FOOD_PLACER_SCAN_EN is defined.
package food_pkg;

    localparam int COORD_W    = 6;
    localparam int DEF_GRID_W = 40;
    localparam int DEF_GRID_H = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_CHECK,
        ST_QUERY,
        ST_DONE
`ifdef FOOD_PLACER_SCAN_EN
        , ST_SCAN
`endif
    } state_e;

    // Coordinates are 6-bit unsigned; widen before comparing so a 64-cell grid still works.
    function automatic logic in_grid(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y,
                                     input int                 grid_w,
                                     input int                 grid_h);
        return (int'(x) < grid_w) && (int'(y) < grid_h);
    endfunction

endpackage

// File: rtl/food_placer_scan.sv
// Raster cell counter (x fastest) used as the fallback search after the LFSR gives up.
// Present only when FOOD_PLACER_SCAN_EN is defined.
`ifdef FOOD_PLACER_SCAN_EN
module food_scan
    import food_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               step_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o
);

    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;

    always_ff @(posedge clk) begin
        if (rst || start_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (step_i) begin
            if (x_q == COORD_W'(GRID_W - 1)) begin
                x_q <= '0;
                y_q <= y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == COORD_W'(GRID_W - 1)) && (y_q == COORD_W'(GRID_H - 1));

endmodule
`endif

// File: rtl/food_placer.sv
// Sequences the LFSR to pick a free grid cell for new food, checking each candidate
// against the snake occupancy store. FOOD_PLACER_SCAN_EN adds a raster-scan fallback.
module food_placer
    import food_pkg::*;
#(
    parameter int GRID_W    = DEF_GRID_W,
    parameter int GRID_H    = DEF_GRID_H,
    parameter int MAX_TRIES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 place_req,
    input  logic [2*COORD_W-1:0] lfsr_data,
    output logic                 lfsr_en,
    output logic                 occ_req,
    output logic [COORD_W-1:0]   occ_x,
    output logic [COORD_W-1:0]   occ_y,
    input  logic                 occ_valid,
    input  logic                 occ_hit,
    output logic                 busy,
    output logic                 food_valid,
    output logic [COORD_W-1:0]   food_x,
    output logic [COORD_W-1:0]   food_y,
    output logic                 fail
);

    localparam int AW = $clog2(MAX_TRIES + 1);

    state_e             state_q;
    logic [AW-1:0]      attempts_q;
    logic               lfsr_en_q;
    logic               occ_req_q;
    logic [COORD_W-1:0] occ_x_q;
    logic [COORD_W-1:0] occ_y_q;
    logic               food_valid_q;
    logic [COORD_W-1:0] food_x_q;
    logic [COORD_W-1:0] food_y_q;
    logic               fail_q;

    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    logic               cand_ok;
    logic               tries_spent;
    logic               occ_ans;
    logic               in_scan;
    logic               exhaust;

    assign cand_x      = lfsr_data[COORD_W-1:0];
    assign cand_y      = lfsr_data[2*COORD_W-1:COORD_W];
    assign cand_ok     = in_grid(cand_x, cand_y, GRID_W, GRID_H);
    assign tries_spent = (attempts_q == AW'(MAX_TRIES));
    // An answer only counts while our own query is outstanding.
    assign occ_ans     = (state_q == ST_QUERY) && occ_req_q && occ_valid;

`ifdef FOOD_PLACER_SCAN_EN
    logic               scan_mode_q;
    logic               scan_step;
    logic [COORD_W-1:0] scan_x;
    logic [COORD_W-1:0] scan_y;
    logic               scan_last;

    assign in_scan   = scan_mode_q;
    assign scan_step = occ_ans && occ_hit && scan_mode_q && !scan_last;

    food_scan #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .start_i (exhaust),
        .step_i  (scan_step),
        .x_o     (scan_x),
        .y_o     (scan_y),
        .last_o  (scan_last)
    );
`else
    assign in_scan = 1'b0;
`endif

    // The LFSR budget is used up either by a rejected or by an occupied final candidate.
    assign exhaust = ((state_q == ST_CHECK) && !cand_ok && tries_spent)
                   || (occ_ans && occ_hit && !in_scan && tries_spent);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            attempts_q   <= '0;
            lfsr_en_q    <= 1'b0;
            occ_req_q    <= 1'b0;
            occ_x_q      <= '0;
            occ_y_q      <= '0;
            food_valid_q <= 1'b0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            fail_q       <= 1'b0;
`ifdef FOOD_PLACER_SCAN_EN
            scan_mode_q  <= 1'b0;
`endif
        end else begin
            lfsr_en_q <= 1'b0;
            fail_q    <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (place_req) begin
                        state_q      <= ST_STEP;
                        lfsr_en_q    <= 1'b1;
                        food_valid_q <= 1'b0;
                        attempts_q   <= '0;
`ifdef FOOD_PLACER_SCAN_EN
                        scan_mode_q  <= 1'b0;
`endif
                    end
                end
                ST_STEP: begin
                    if (!tries_spent) begin
                        attempts_q <= attempts_q + 1'b1;
                    end
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (cand_ok) begin
                        state_q   <= ST_QUERY;
                        occ_req_q <= 1'b1;
                        occ_x_q   <= cand_x;
                        occ_y_q   <= cand_y;
                    end else if (!tries_spent) begin
                        state_q   <= ST_STEP;
                        lfsr_en_q <= 1'b1;
                    end
                end
                ST_QUERY: begin
                    if (occ_ans) begin
                        occ_req_q <= 1'b0;
                        if (!occ_hit) begin
                            state_q <= ST_DONE;
`ifdef FOOD_PLACER_SCAN_EN
                        end else if (scan_mode_q) begin
                            if (scan_last) begin
                                fail_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_SCAN;
                            end
`endif
                        end else if (!tries_spent) begin
                            state_q   <= ST_STEP;
                            lfsr_en_q <= 1'b1;
                        end
                    end
                end
`ifdef FOOD_PLACER_SCAN_EN
                ST_SCAN: begin
                    state_q   <= ST_QUERY;
                    occ_req_q <= 1'b1;
                    occ_x_q   <= scan_x;
                    occ_y_q   <= scan_y;
                end
`endif
                ST_DONE: begin
                    food_x_q     <= occ_x_q;
                    food_y_q     <= occ_y_q;
                    food_valid_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // Exhaustion overrides the per-state next state chosen above.
            if (exhaust) begin
`ifdef FOOD_PLACER_SCAN_EN
                state_q     <= ST_SCAN;
                scan_mode_q <= 1'b1;
`else
                state_q     <= ST_IDLE;
                fail_q      <= 1'b1;
`endif
            end
        end
    end

    assign lfsr_en    = lfsr_en_q;
    assign occ_req    = occ_req_q;
    assign occ_x      = occ_x_q;
    assign occ_y      = occ_y_q;
    assign busy       = (state_q != ST_IDLE);
    assign food_valid = food_valid_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: directed LFSR sequences and occupancy answers,
// outcomes checked by a monitor that pops expected placements/failures.
module tb_food_placer;

    typedef struct packed {
        logic       is_fail;
        logic [5:0] x;
        logic [5:0] y;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        place_req;
    logic [11:0] lfsr_data;
    logic        lfsr_en;
    logic        occ_req;
    logic [5:0]  occ_x;
    logic [5:0]  occ_y;
    logic        occ_valid;
    logic        occ_hit;
    logic        busy;
    logic        food_valid;
    logic [5:0]  food_x;
    logic [5:0]  food_y;
    logic        fail;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t sb[$];

    // LFSR stand-in: table indexed by steps taken since the current placement began
    logic [11:0] lfsr_vals [64];
    int          lfsr_idx  = 0;
    int          lfsr_base = 0;

    // occupancy responder configuration
    int         occ_delay     = 1;
    int         hit_n         = 0;
    bit         always_hit    = 0;
    bit         free_en       = 0;
    logic [5:0] free_x        = '0;
    logic [5:0] free_y        = '0;
    bit         resp_late     = 0;
    int         queries_total = 0;
    int         q_start       = 0;

    int start_cyc = 0;
    int rise_cyc  = 0;
    int n_out     = 0;

    assign lfsr_data = lfsr_vals[(lfsr_idx - lfsr_base) & 63];

    food_placer #(
        .GRID_W    (40),
        .GRID_H    (30),
        .MAX_TRIES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .place_req  (place_req),
        .lfsr_data  (lfsr_data),
        .lfsr_en    (lfsr_en),
        .occ_req    (occ_req),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_valid  (occ_valid),
        .occ_hit    (occ_hit),
        .busy       (busy),
        .food_valid (food_valid),
        .food_x     (food_x),
        .food_y     (food_y),
        .fail       (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // LFSR model: advance once per cycle that lfsr_en was high; pulses must be one cycle wide
    initial begin
        logic s;
        logic prev_s;
        prev_s = 1'b0;
        forever begin
            @(negedge clk);
            s = lfsr_en;
            if (s) check("lfsr_en_single_cycle", int'(prev_s), 0);
            prev_s = s;
            @(posedge clk);
            #1;
            if (s) lfsr_idx++;
        end
    end

    // Occupancy responder
    initial begin
        logic [5:0] qx;
        logic [5:0] qy;
        int         qn;
        occ_valid = 1'b0;
        occ_hit   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (occ_req) begin
                qx = occ_x;
                qy = occ_y;
                for (int d = 1; d <= occ_delay; d++) begin
                    @(posedge clk);
                    #1;
                    if (!resp_late)
                        check("occ_stable", int'({occ_req, occ_x, occ_y}), int'({1'b1, qx, qy}));
                end
                qn = queries_total - q_start;
                if (always_hit)
                    occ_hit = !(free_en && qx == free_x && qy == free_y);
                else
                    occ_hit = (qn < hit_n);
                occ_valid = 1'b1;
                queries_total++;
                @(posedge clk);
                #1;
                occ_valid = 1'b0;
                occ_hit   = 1'b0;
                check("occ_req_drop", int'(occ_req), 0);
            end
        end
    end

    // Monitor: pops the scoreboard on each fail pulse or food_valid rising edge
    initial begin
        logic fv_prev;
        exp_t e;
        fv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fail) begin
                n_out++;
                $display("out %0d: fail pulse at cycle %0d", n_out, cyc);
                if (sb.size() == 0) begin
                    check("unexpected_fail", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("outcome_is_fail", 1, int'(e.is_fail));
                end
            end
            if (food_valid && !fv_prev) begin
                rise_cyc = cyc;
                n_out++;
                $display("out %0d: food (%0d,%0d) at cycle %0d", n_out, food_x, food_y, cyc);
                if (sb.size() == 0) begin
                    check("unexpected_food", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("outcome_is_food", 0, int'(e.is_fail));
                    check("food_xy", int'({food_x, food_y}), int'({e.x, e.y}));
                end
            end
            fv_prev = food_valid;
        end
    end

    task automatic fill_lfsr(input logic [11:0] v);
        for (int i = 0; i < 64; i++) lfsr_vals[i] = v;
    endtask

    task automatic run_place(input logic efail, input logic [5:0] ex, input logic [5:0] ey,
                             input bit repulse, output int steps, output int queries);
        bit done;
        @(posedge clk);
        #1;
        lfsr_base = lfsr_idx;
        q_start   = queries_total;
        start_cyc = cyc;
        sb.push_back('{efail, ex, ey});
        place_req = 1'b1;
        @(posedge clk);
        #1;
        place_req = 1'b0;
        check("busy_after_req", int'(busy), 1);
        check("food_valid_cleared", int'(food_valid), 0);
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(posedge clk);
            #1;
            place_req = 1'b0;
            if (!busy) done = 1'b1;
            else if (repulse && (c == 1 || c == 3)) place_req = 1'b1;
        end
        place_req = 1'b0;
        if (!done) check("placement_timeout", 0, 1);
        @(negedge clk);
        #1;
        steps   = lfsr_idx - lfsr_base;
        queries = queries_total - q_start;
    endtask

    initial begin
        int  steps;
        int  queries;
        bit  seen;
        rst       = 1'b1;
        place_req = 1'b0;
        fill_lfsr(12'h000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_lfsr_en", int'(lfsr_en), 0);
        check("rst_occ_req", int'(occ_req), 0);
        check("rst_occ_xy", int'({occ_x, occ_y}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_food_valid", int'(food_valid), 0);
        check("rst_food_xy", int'({food_x, food_y}), 0);
        check("rst_fail", int'(fail), 0);

        // best case: seed 001, one step to (5,3), immediate miss
        fill_lfsr(12'h000);
        lfsr_vals[0] = 12'h001;
        lfsr_vals[1] = 12'h0C5;
        run_place(1'b0, 6'd5, 6'd3, 1'b0, steps, queries);
        check("t1_latency", rise_cyc - start_cyc, 6);
        check("t1_lfsr_steps", steps, 1);
        check("t1_queries", queries, 1);

        // grid edges: x=40, y=30, (63,63) rejected; (39,29) accepted
        fill_lfsr(12'h000);
        lfsr_vals[1] = 12'h028;
        lfsr_vals[2] = 12'h780;
        lfsr_vals[3] = 12'hFFF;
        lfsr_vals[4] = 12'h767;
        run_place(1'b0, 6'd39, 6'd29, 1'b0, steps, queries);
        check("t2_lfsr_steps", steps, 4);
        check("t2_queries", queries, 1);

        // three occupied answers, slow responder, one out-of-grid candidate in between
        fill_lfsr(12'h000);
        lfsr_vals[1] = 12'h041;
        lfsr_vals[2] = 12'h0B2;
        lfsr_vals[3] = 12'h082;
        lfsr_vals[4] = 12'h0C3;
        lfsr_vals[5] = 12'h247;
        hit_n     = 3;
        occ_delay = 5;
        run_place(1'b0, 6'd7, 6'd9, 1'b0, steps, queries);
        check("t3_lfsr_steps", steps, 5);
        check("t3_queries", queries, 4);
        hit_n     = 0;
        occ_delay = 1;

        // every LFSR candidate occupied; only (2,1) free for a raster search
        fill_lfsr(12'h000);
        always_hit = 1'b1;
        free_en    = 1'b1;
        free_x     = 6'd2;
        free_y     = 6'd1;
`ifdef FOOD_PLACER_SCAN_EN
        run_place(1'b0, 6'd2, 6'd1, 1'b0, steps, queries);
        check("t4_queries", queries, 8 + 43);
`else
        run_place(1'b1, 6'd0, 6'd0, 1'b0, steps, queries);
        check("t4_queries", queries, 8);
        check("t4_food_valid_low", int'(food_valid), 0);
`endif
        check("t4_lfsr_steps", steps, 8);

        // every LFSR candidate off-grid: budget runs out in CHECK
        fill_lfsr(12'hFFF);
`ifdef FOOD_PLACER_SCAN_EN
        run_place(1'b0, 6'd2, 6'd1, 1'b0, steps, queries);
        check("t5_queries", queries, 43);
`else
        run_place(1'b1, 6'd0, 6'd0, 1'b0, steps, queries);
        check("t5_queries", queries, 0);
`endif
        check("t5_lfsr_steps", steps, 8);
        always_hit = 1'b0;
        free_en    = 1'b0;

        // reset while a query is outstanding; answer arrives after reset
        fill_lfsr(12'h000);
        lfsr_vals[1] = 12'h104;
        resp_late    = 1'b1;
        @(posedge clk);
        #1;
        lfsr_base = lfsr_idx;
        place_req = 1'b1;
        @(posedge clk);
        #1;
        place_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (occ_req) seen = 1'b1;
        end
        check("t6_reached_query", int'(seen), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_occ_req", int'(occ_req), 0);
        check("t6_occ_xy", int'({occ_x, occ_y}), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_food_xy", int'({food_x, food_y}), 0);
        repeat (4) @(posedge clk);
        #1;
        check("t6_busy_after", int'(busy), 0);
        check("t6_food_valid", int'(food_valid), 0);
        check("t6_lfsr_en", int'(lfsr_en), 0);
        resp_late = 1'b0;

        // extra requests while busy are ignored
        fill_lfsr(12'h000);
        lfsr_vals[1] = 12'h50A;
        occ_delay    = 3;
        run_place(1'b0, 6'd10, 6'd20, 1'b1, steps, queries);
        check("t7_lfsr_steps", steps, 1);
        check("t7_queries", queries, 1);
        repeat (6) @(posedge clk);
        #1;
        check("t7_idle_after", int'(busy), 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
